// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared state encoding, default parameters and counter width helper for btn_event.
// Auto-repeat support is selected with BTN_EVENT_REPEAT_EN.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        REPEAT  = 2'd2
    } btn_state_e;

    localparam int DEF_W           = 2;
    localparam int DEF_TICK_DIV    = 1_250_000;
    localparam int DEF_STABLE      = 3;
    localparam int DEF_DELAY_TICKS = 50;
    localparam int DEF_RATE_TICKS  = 10;

    // Bits needed to hold values 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/btn_event_ch.sv
// rtl/btn_event_ch.sv - one debounced button channel: synchroniser, run/hold counters, FSM, pulse register.
// Hold counter and REPEAT state exist only when BTN_EVENT_REPEAT_EN is defined.
module btn_event_ch
    import btn_pkg::*;
#(
    parameter int STABLE      = DEF_STABLE
`ifdef BTN_EVENT_REPEAT_EN
   ,parameter int DELAY_TICKS = DEF_DELAY_TICKS
   ,parameter int RATE_TICKS  = DEF_RATE_TICKS
`endif
) (
    input  logic CLK,
    input  logic RSTN,
    input  logic tick_i,
    input  logic btn_i,
    output logic pulse_o,
    output logic hold_o
);

    localparam int RW = cnt_width(STABLE);

    logic          sync1_q, sync2_q;
    btn_state_e    state_q, state_d;
    logic [RW-1:0] run_q, run_d, run_inc;
    logic          pulse_q, pulse_d;

`ifdef BTN_EVENT_REPEAT_EN
    localparam int HW = cnt_width((DELAY_TICKS > RATE_TICKS) ? DELAY_TICKS : RATE_TICKS);
    logic [HW-1:0] hold_q, hold_d, hold_inc;
`endif

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        pulse_d = 1'b0;
        run_inc = (run_q == RW'(STABLE)) ? run_q : run_q + 1'b1;
`ifdef BTN_EVENT_REPEAT_EN
        hold_d   = hold_q;
        hold_inc = hold_q + 1'b1;
`endif
        if (tick_i) begin
            case (state_q)
                IDLE: begin
                    if (!sync2_q) begin
                        run_d = '0;
                    end else if (run_inc == RW'(STABLE)) begin
                        state_d = PRESSED;
                        pulse_d = 1'b1;
                        run_d   = '0;
`ifdef BTN_EVENT_REPEAT_EN
                        hold_d  = '0;
`endif
                    end else begin
                        run_d = run_inc;
                    end
                end
                default: begin
                    // Run counter tracks low samples here; the hold counter keeps
                    // running until the release is actually accepted.
                    if (!sync2_q && run_inc == RW'(STABLE)) begin
                        state_d = IDLE;
                        run_d   = '0;
                    end else begin
                        run_d = sync2_q ? '0 : run_inc;
`ifdef BTN_EVENT_REPEAT_EN
                        hold_d = hold_inc;
                        if (state_q == PRESSED && hold_inc == HW'(DELAY_TICKS)) begin
                            state_d = REPEAT;
                            pulse_d = 1'b1;
                            hold_d  = '0;
                        end else if (state_q == REPEAT && hold_inc == HW'(RATE_TICKS)) begin
                            pulse_d = 1'b1;
                            hold_d  = '0;
                        end
`endif
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= IDLE;
            run_q   <= '0;
            pulse_q <= 1'b0;
`ifdef BTN_EVENT_REPEAT_EN
            hold_q  <= '0;
`endif
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            state_q <= state_d;
            run_q   <= run_d;
            pulse_q <= pulse_d;
`ifdef BTN_EVENT_REPEAT_EN
            hold_q  <= hold_d;
`endif
        end
    end

    assign pulse_o = pulse_q;
    assign hold_o  = (state_q != IDLE);

endmodule

// File: rtl/btn_event.sv
// rtl/btn_event.sv - push-button debouncer: shared sample-tick divider feeding W independent channels.
// Define BTN_EVENT_REPEAT_EN to build auto-repeat while a button is held.
module btn_event
    import btn_pkg::*;
#(
    parameter int W           = DEF_W,
    parameter int TICK_DIV    = DEF_TICK_DIV,
    parameter int STABLE      = DEF_STABLE,
    parameter int DELAY_TICKS = DEF_DELAY_TICKS,
    parameter int RATE_TICKS  = DEF_RATE_TICKS
) (
    input  logic         CLK,
    input  logic         RSTN,
    input  logic [W-1:0] BTNIN,
    output logic [W-1:0] BTNOUT,
    output logic [W-1:0] BTNHOLD
);

    localparam int DW = cnt_width(TICK_DIV - 1);

    logic [DW-1:0] div_q, div_d;
    logic          tick;

    // Out-of-range parameter sets elaborate this empty marker block.
    if (TICK_DIV < 2 || STABLE < 2 || STABLE > 15 || DELAY_TICKS < 1 || RATE_TICKS < 1) begin : g_bad_params
    end

    always_comb begin
        tick  = (div_q == DW'(TICK_DIV - 1));
        div_d = tick ? '0 : div_q + 1'b1;
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    for (genvar g = 0; g < W; g++) begin : g_ch
        btn_event_ch #(
            .STABLE      (STABLE)
`ifdef BTN_EVENT_REPEAT_EN
           ,.DELAY_TICKS (DELAY_TICKS)
           ,.RATE_TICKS  (RATE_TICKS)
`endif
        ) u_ch (
            .CLK     (CLK),
            .RSTN    (RSTN),
            .tick_i  (tick),
            .btn_i   (BTNIN[g]),
            .pulse_o (BTNOUT[g]),
            .hold_o  (BTNHOLD[g])
        );
    end

endmodule

// File: tb/tb_btn_event.sv
// tb/tb_btn_event.sv - directed bench for btn_event; expectations follow BTN_EVENT_REPEAT_EN.
module tb_btn_event;

    logic       CLK  = 1'b0;
    logic       RSTN = 1'b0;
    logic [1:0] BTNIN = 2'b00;
    logic [1:0] BTNOUT;
    logic [1:0] BTNHOLD;

    int total = 0;
    int bad   = 0;
    int cyc;
    int q0[$];
    int q1[$];
    int exp_q[$];
    bit pat[8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [1:0] seen;

    btn_event #(
        .W(2), .TICK_DIV(4), .STABLE(3), .DELAY_TICKS(8), .RATE_TICKS(2)
    ) dut (
        .CLK(CLK), .RSTN(RSTN), .BTNIN(BTNIN), .BTNOUT(BTNOUT), .BTNHOLD(BTNHOLD)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK or negedge RSTN) begin
        if (!RSTN) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    always @(negedge CLK) begin
        if (!RSTN) begin
            q0.delete();
            q1.delete();
        end else begin
            if (BTNOUT[0]) q0.push_back(cyc);
            if (BTNOUT[1]) q1.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int c);
        int n = 0;
        while (cyc != c && n < 4000) begin
            @(negedge CLK);
            n++;
        end
        #1;
        if (cyc != c) begin
            total++;
            bad++;
            $error("FAIL wait_cyc: observed=%0d expected=%0d", cyc, c);
        end
    endtask

    task automatic do_reset(input logic [1:0] b);
        @(negedge CLK);
        RSTN  = 1'b0;
        BTNIN = b;
        repeat (3) @(negedge CLK);
        RSTN = 1'b1;
    endtask

    task automatic chk_list(input string tag);
        chk({tag, " count"}, q0.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < q0.size(); i++)
            chk($sformatf("%s pulse%0d", tag, i), q0[i], exp_q[i]);
    endtask

    initial begin
        // Reset state with a button already held
        BTNIN = 2'b01;
        repeat (3) @(negedge CLK);
        #1;
        chk("reset BTNOUT", BTNOUT, 2'b00);
        chk("reset BTNHOLD", BTNHOLD, 2'b00);

        // Clean press of button 0, held 20 ticks past the press pulse
        do_reset(2'b01);
        wait_cyc(11);
        chk("s1 pre BTNOUT", BTNOUT, 2'b00);
        chk("s1 pre BTNHOLD", BTNHOLD, 2'b00);
        wait_cyc(12);
        chk("s1 press BTNOUT", BTNOUT, 2'b01);
        chk("s1 press BTNHOLD", BTNHOLD, 2'b01);
        wait_cyc(13);
        chk("s1 single cycle", BTNOUT, 2'b00);
        wait_cyc(43);
        chk("s1 pre repeat", BTNOUT, 2'b00);
        wait_cyc(44);
`ifdef BTN_EVENT_REPEAT_EN
        chk("s1 first repeat", BTNOUT, 2'b01);
`else
        chk("s1 no repeat", BTNOUT, 2'b00);
`endif
        wait_cyc(92);
        BTNIN = 2'b00;
        wait_cyc(103);
        chk("s1 hold before release", BTNHOLD, 2'b01);
        wait_cyc(104);
        chk("s1 hold after release", BTNHOLD, 2'b00);
        wait_cyc(112);
        exp_q.delete();
        exp_q.push_back(12);
`ifdef BTN_EVENT_REPEAT_EN
        for (int c = 44; c <= 100; c += 8) exp_q.push_back(c);
`endif
        chk_list("s1");
        chk("s1 other channel", q1.size(), 0);

        // Bounce pattern, one value per tick
        do_reset(2'b00);
        for (int j = 0; j < 8; j++) begin
            wait_cyc(1 + 4 * j);
            BTNIN[0] = pat[j];
        end
        wait_cyc(31);
        chk("s2 no early pulse", q0.size(), 0);
        chk("s2 no early hold", BTNHOLD, 2'b00);
        wait_cyc(32);
        chk("s2 press BTNOUT", BTNOUT, 2'b01);
        chk("s2 press BTNHOLD", BTNHOLD, 2'b01);
        wait_cyc(40);
        chk("s2 pulse count", q0.size(), 1);
        BTNIN = 2'b00;

        // One-cycle glitch on button 1 between ticks
        do_reset(2'b00);
        seen = 2'b00;
        for (int c = 1; c <= 40; c++) begin
            wait_cyc(c);
            if (c == 4) BTNIN[1] = 1'b1;
            if (c == 5) BTNIN[1] = 1'b0;
            seen = seen | BTNOUT | BTNHOLD;
        end
        chk("s3 glitch activity", seen, 2'b00);
        chk("s3 glitch pulses", q1.size(), 0);

        // Both buttons together, then reset while held
        do_reset(2'b11);
        wait_cyc(12);
        chk("s4 both press", BTNOUT, 2'b11);
        wait_cyc(13);
        chk("s4 both single", BTNOUT, 2'b00);
`ifdef BTN_EVENT_REPEAT_EN
        wait_cyc(44);
        chk("s4 both repeat", BTNOUT, 2'b11);
        wait_cyc(50);
        chk("s4 q0 size", q0.size(), 2);
        chk("s4 q1 size", q1.size(), 2);
        chk("s4 q1 repeat", q1[1], 44);
        wait_cyc(52);
        chk("s4 pulse in flight", BTNOUT, 2'b11);
`else
        wait_cyc(50);
        chk("s4 q0 size", q0.size(), 1);
        chk("s4 q1 size", q1.size(), 1);
        wait_cyc(52);
        chk("s4 no repeat", BTNOUT, 2'b00);
`endif
        chk("s4 held", BTNHOLD, 2'b11);
        RSTN = 1'b0;
        #1;
        chk("s4 reset BTNOUT", BTNOUT, 2'b00);
        chk("s4 reset BTNHOLD", BTNHOLD, 2'b00);
        repeat (3) @(negedge CLK);
        RSTN = 1'b1;
        wait_cyc(11);
        chk("s4 fresh not early", BTNOUT, 2'b00);
        wait_cyc(12);
        chk("s4 fresh press", BTNOUT, 2'b11);
        wait_cyc(176);
        exp_q.delete();
        exp_q.push_back(12);
`ifdef BTN_EVENT_REPEAT_EN
        for (int c = 44; c <= 172; c += 8) exp_q.push_back(c);
`endif
        chk_list("s4");
        chk("s4 lockstep", q1.size(), exp_q.size());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
